mult_lut_seq: RTL and testbench

//   Multi-cycle unsigned WIDTH x WIDTH multiplier built around one shared
//   6x6 mult_lut instance. Splits each operand into 6-bit digits and walks

---
 rtl/mult_lut_seq.sv | 144 ++++++++++++++
 tb/tb_mult_lut_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_lut_seq.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier that walks every pair of
// 6-bit operand digits through one shared 6x6 lookup multiplier, one pair per
// cycle, shifting and accumulating partial products.

// Combinational 6x6 unsigned product table: addr_i = {a_digit, b_digit}.
module mult_lut (
    input  logic [11:0] addr_i,
    output logic [11:0] data_o
);
    assign data_o = 12'(addr_i[11:6]) * 12'(addr_i[5:0]);
endmodule

module mult_lut_seq #(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int DIGITS = WIDTH / 6;
    localparam int ACC_W  = 2 * WIDTH;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    // Operands must split evenly into 6-bit digits.
    if ((WIDTH % 6) != 0 || WIDTH < 6) begin : g_bad_width
        $error("mult_lut_seq: WIDTH must be a positive multiple of 6");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      i_q, i_d;
    logic [CW-1:0]      j_q, j_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic [11:0]        lut_addr;
    logic [11:0]        lut_data;
    logic [ACC_W-1:0]   pp_shifted;
    int unsigned        shamt;

    // The only driver of the shared LUT address: current digit pair.
    assign lut_addr = {a_q[6*i_q +: 6], b_q[6*j_q +: 6]};

    mult_lut u_lut (
        .addr_i (lut_addr),
        .data_o (lut_data)
    );

    // Align the partial product to digit weight 6*(i+j).
    always_comb begin
        shamt      = 6 * (32'(i_q) + 32'(j_q));
        pp_shifted = ACC_W'(lut_data) << shamt;
    end

    // Next-state logic: accept, iterate digit pairs (j inner), publish result.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp_shifted;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mult_lut_seq.sv
// Directed self-checking bench for mult_lut_seq (WIDTH=24, 17-cycle latency).
`timescale 1ns/1ps
module tb_mult_lut_seq;
    localparam int W = 24;
    localparam int LAT = 17;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           ready_o;
    logic           done_o;
    logic [2*W-1:0] result_o;

    int n_cmp = 0;
    int n_err = 0;

    mult_lut_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge (acceptance edge T), return #1 after T.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = ~a;   // operand changes while busy must not matter
        b_i     = ~b;
    endtask

    // Count edges after T until done_o is seen; 'base' edges already elapsed.
    task automatic wait_done(input int base, output int lat);
        lat = -1;
        for (int k = base + 1; k <= base + 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
        int lat;
        check({tag, "_ready_pre"}, 64'(ready_o), 64'd1);
        launch(a, b);
        check({tag, "_ready_busy"}, 64'(ready_o), 64'd0);
        wait_done(0, lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_result"}, 64'(result_o), 64'(exp));
        check({tag, "_ready_post"}, 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, 64'(done_o), 64'd0);
        check({tag, "_hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;
        logic [W-1:0] ra, rb;

        // Reset state
        #12;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1..3 plus digit-placement vectors
        do_op("t1_3x5", 24'd3, 24'd5, 48'd15);
        do_op("t2_max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        do_op("t3_zero", 24'd0, 24'h123456, 48'd0);
        do_op("t_63x63", 24'h00003F, 24'h00003F, 48'h000000000F81);
        do_op("t_hi_dig", 24'h040000, 24'h000003, 48'h0000000C0000);
        do_op("t_cross", 24'h000003, 24'h040000, 48'h0000000C0000);

        // 4: start pulse during CALC is ignored
        launch(24'd7, 24'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        a_i     = 24'd100;
        b_i     = 24'd100;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(5, lat);
        check("t4_latency", 64'(lat), 64'(LAT));
        check("t4_result", 64'(result_o), 64'd63);
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        check("t4_no_extra_done", 64'(dones), 64'd0);

        // 5: reset mid-operation discards it
        launch(24'd1000, 24'd1000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 64'(ready_o), 64'd1);
        check("t5_rst_done", 64'(done_o), 64'd0);
        check("t5_rst_result", 64'(result_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        check("t5_no_done", 64'(dones), 64'd0);
        check("t5_result_zero", 64'(result_o), 64'd0);
        do_op("t5_restart", 24'd2, 24'd3, 48'd6);

        // 6: back-to-back with start_i held high
        dones = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra = W'($urandom);
            rb = W'($urandom);
            start_i = 1'b1;
            a_i     = ra;
            b_i     = rb;
            @(posedge clk);
            #1;
            a_i = ~ra;
            b_i = ~rb;
            wait_done(0, lat);
            if (lat != LAT || result_o !== (48'(ra) * 48'(rb))) dones++;
            if (n < 3 || n == 999) begin
                check("t6_latency", 64'(lat), 64'(LAT));
                check("t6_result", 64'(result_o), 64'(48'(ra) * 48'(rb)));
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        check("t6_errors", 64'(dones), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
